// File: rtl/fmul_if.sv
// Operand/result handshake bundle for the pipelined floating-point multiplier.
interface fmul_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic [3:0]   flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, y, flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, y, flags
    );
endinterface

// File: rtl/fmul_pipe.sv
// Three-stage RNE floating-point multiplier (flush-to-zero) with valid/ready backpressure.
// Define FMUL_STICKY_EN to add the accumulated-flag register and its clear input.
module fmul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic       clk,
    input  logic       rst_n,
    fmul_if.slave      bus
`ifdef FMUL_STICKY_EN
    ,
    output logic [3:0] sticky,
    input  logic       sticky_clr
`endif
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int EW2 = EXP_W + 2;
    localparam int PW  = 2 * (MAN_W + 1);
    localparam logic signed [EW2-1:0] BIAS  = EW2'(2 ** (EXP_W - 1) - 1);
    localparam logic signed [EW2-1:0] EMAX  = EW2'(2 ** EXP_W - 1);
    localparam logic signed [EW2-1:0] EZERO = '0;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // Returns {carry, fraction}; carry means the significand rolled over to 2.0.
    function automatic logic [MAN_W:0] rne_round(input logic [MAN_W-1:0] frac,
                                                 input logic g, input logic r, input logic s);
        logic inc;
        inc = g & (r | s | frac[0]);
        return {1'b0, frac} + (MAN_W+1)'(inc);
    endfunction

    logic stall;
    logic adv;
    logic vld_p0, vld_p1, vld_p2;

    assign stall         = vld_p2 && !bus.out_ready;
    assign adv           = !stall;
    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_p2;

    // ---- S1: operand capture, unpack, classify ----
    logic             sign_a_p0, sign_b_p0;
    logic [EXP_W-1:0] exp_a_p0, exp_b_p0;
    logic [MAN_W-1:0] frac_a_p0, frac_b_p0;
    logic             nan_a_p0, nan_b_p0, inf_a_p0, inf_b_p0, zero_a_p0, zero_b_p0;

    always_ff @(posedge clk) begin
        if (adv) begin
            sign_a_p0 <= bus.a[W-1];
            sign_b_p0 <= bus.b[W-1];
            exp_a_p0  <= bus.a[W-2 -: EXP_W];
            exp_b_p0  <= bus.b[W-2 -: EXP_W];
            frac_a_p0 <= bus.a[MAN_W-1:0];
            frac_b_p0 <= bus.b[MAN_W-1:0];
            nan_a_p0  <= (&bus.a[W-2 -: EXP_W]) && (|bus.a[MAN_W-1:0]);
            nan_b_p0  <= (&bus.b[W-2 -: EXP_W]) && (|bus.b[MAN_W-1:0]);
            inf_a_p0  <= (&bus.a[W-2 -: EXP_W]) && !(|bus.a[MAN_W-1:0]);
            inf_b_p0  <= (&bus.b[W-2 -: EXP_W]) && !(|bus.b[MAN_W-1:0]);
            // Denormals count as zero.
            zero_a_p0 <= !(|bus.a[W-2 -: EXP_W]);
            zero_b_p0 <= !(|bus.b[W-2 -: EXP_W]);
        end
    end

    // ---- S2: sign, exponent sum, significand product ----
    logic                  sign_p1;
    logic signed [EW2-1:0] exp_p1;
    logic [PW-1:0]         prod_p1;
    logic                  nan_p1, inf_p1, zero_p1;

    always_ff @(posedge clk) begin
        if (adv) begin
            sign_p1 <= sign_a_p0 ^ sign_b_p0;
            exp_p1  <= $signed({2'b00, exp_a_p0}) + $signed({2'b00, exp_b_p0}) - BIAS;
            prod_p1 <= PW'({1'b1, frac_a_p0}) * PW'({1'b1, frac_b_p0});
            nan_p1  <= nan_a_p0 | nan_b_p0 | (inf_a_p0 & zero_b_p0) | (zero_a_p0 & inf_b_p0);
            inf_p1  <= inf_a_p0 | inf_b_p0;
            zero_p1 <= zero_a_p0 | zero_b_p0;
        end
    end

    // ---- S3: normalise, round, pack, flags ----
    logic [PW-2:0]         norm;
    logic [MAN_W:0]        rnd;
    logic signed [EW2-1:0] exp_r;
    logic                  inexact;
    logic [W-1:0]          y_nxt;
    logic [3:0]            flags_nxt;
    logic [W-1:0]          y_p2;
    logic [3:0]            flags_p2;

    always_comb begin
        norm      = prod_p1[PW-1] ? prod_p1[PW-2:0] : {prod_p1[PW-3:0], 1'b0};
        rnd       = rne_round(norm[PW-2 -: MAN_W], norm[MAN_W], norm[MAN_W-1], |norm[MAN_W-2:0]);
        exp_r     = exp_p1 + EW2'(prod_p1[PW-1]) + EW2'(rnd[MAN_W]);
        inexact   = norm[MAN_W] | norm[MAN_W-1] | (|norm[MAN_W-2:0]);
        y_nxt     = {sign_p1, exp_r[EXP_W-1:0], rnd[MAN_W-1:0]};
        flags_nxt = {3'b000, inexact};
        if (nan_p1) begin
            y_nxt     = QNAN;
            flags_nxt = 4'b1000;
        end else if (inf_p1) begin
            y_nxt     = {sign_p1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_nxt = 4'b0000;
        end else if (zero_p1) begin
            y_nxt     = {sign_p1, {(W-1){1'b0}}};
            flags_nxt = 4'b0000;
        end else if (exp_r >= EMAX) begin
            y_nxt     = {sign_p1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_nxt = 4'b0101;
        end else if (exp_r <= EZERO) begin
            y_nxt     = {sign_p1, {(W-1){1'b0}}};
            flags_nxt = 4'b0011;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0   <= 1'b0;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            y_p2     <= '0;
            flags_p2 <= '0;
        end else if (adv) begin
            vld_p0 <= bus.in_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                y_p2     <= y_nxt;
                flags_p2 <= flags_nxt;
            end
        end
    end

    assign bus.y     = y_p2;
    assign bus.flags = flags_p2;

`ifdef FMUL_STICKY_EN
    // A transfer in the clear cycle still records its own flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky <= 4'b0000;
        end else if (vld_p2 && bus.out_ready) begin
            sticky <= (sticky_clr ? 4'b0000 : sticky) | flags_p2;
        end else if (sticky_clr) begin
            sticky <= 4'b0000;
        end
    end
`endif
endmodule

// File: tb/tb_fmul_pipe.sv
// Directed testbench for fmul_pipe (EXP_W=8, MAN_W=23); sticky checks when FMUL_STICKY_EN is defined.
module tb_fmul_pipe;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    fmul_if #(.EXP_W(8), .MAN_W(23)) bus ();

`ifdef FMUL_STICKY_EN
    logic [3:0] sticky;
    logic       sticky_clr;
    fmul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .sticky(sticky), .sticky_clr(sticky_clr)
    );
`else
    fmul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one product into an empty pipe and samples the outputs three edges later.
    task automatic run_one(input logic [31:0] ta, input logic [31:0] tb_v,
                           output logic ov, output logic [31:0] ty, output logic [3:0] tf);
        bus.in_valid = 1'b1;
        bus.a        = ta;
        bus.b        = tb_v;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        ov = bus.out_valid;
        ty = bus.y;
        tf = bus.flags;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
`ifdef FMUL_STICKY_EN
        sticky_clr = 1'b0;
`endif
        step(); step(); step();
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        tests++; if (bus.y !== 32'h0) begin fails++; $display("FAIL reset_y: got %h expected 00000000", bus.y); end
        tests++; if (bus.flags !== 4'h0) begin fails++; $display("FAIL reset_flags: got %b expected 0000", bus.flags); end
`ifdef FMUL_STICKY_EN
        tests++; if (sticky !== 4'h0) begin fails++; $display("FAIL reset_sticky: got %b expected 0000", sticky); end
`endif
        rst_n = 1'b1;
        step();
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_latency();
        bus.in_valid = 1'b1;
        bus.a        = 32'h3FC00000;
        bus.b        = 32'h40000000;
        step();
        bus.in_valid = 1'b0;
        step();
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL latency_early: out_valid got %b expected 0", bus.out_valid); end
        step();
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL latency_valid: got %b expected 1", bus.out_valid); end
        tests++; if (bus.y !== 32'h40400000) begin fails++; $display("FAIL latency_y: got %h expected 40400000", bus.y); end
        tests++; if (bus.flags !== 4'b0000) begin fails++; $display("FAIL latency_flags: got %b expected 0000", bus.flags); end
    endtask

    task automatic test_arith();
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic [31:0] ey [5];
        logic [3:0]  ef [5];
        logic        ov;
        logic [31:0] ty;
        logic [3:0]  tf;
        va[0] = 32'hBFC00000; vb[0] = 32'h40000000; ey[0] = 32'hC0400000; ef[0] = 4'b0000;
        va[1] = 32'h3F800001; vb[1] = 32'h3F800001; ey[1] = 32'h3F800002; ef[1] = 4'b0001;
        va[2] = 32'h3F800001; vb[2] = 32'h3FC00000; ey[2] = 32'h3FC00002; ef[2] = 4'b0001;
        va[3] = 32'h3F800003; vb[3] = 32'h3FC00000; ey[3] = 32'h3FC00004; ef[3] = 4'b0001;
        va[4] = 32'h3FFFFFFF; vb[4] = 32'h3FFFFFFF; ey[4] = 32'h407FFFFE; ef[4] = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            run_one(va[i], vb[i], ov, ty, tf);
            tests++; if (ov !== 1'b1) begin fails++; $display("FAIL arith%0d_valid: got %b expected 1", i, ov); end
            tests++; if (ty !== ey[i]) begin fails++; $display("FAIL arith%0d_y: got %h expected %h", i, ty, ey[i]); end
            tests++; if (tf !== ef[i]) begin fails++; $display("FAIL arith%0d_flags: got %b expected %b", i, tf, ef[i]); end
        end
    endtask

    task automatic test_specials();
        logic [31:0] va [7];
        logic [31:0] vb [7];
        logic [31:0] ey [7];
        logic [3:0]  ef [7];
        logic        ov;
        logic [31:0] ty;
        logic [3:0]  tf;
        va[0] = 32'h7F000000; vb[0] = 32'h7F000000; ey[0] = 32'h7F800000; ef[0] = 4'b0101;
        va[1] = 32'h7F800000; vb[1] = 32'h00000000; ey[1] = 32'h7FC00000; ef[1] = 4'b1000;
        va[2] = 32'h00800000; vb[2] = 32'h00800000; ey[2] = 32'h00000000; ef[2] = 4'b0011;
        va[3] = 32'h00000001; vb[3] = 32'h3F800000; ey[3] = 32'h00000000; ef[3] = 4'b0000;
        va[4] = 32'h7FC00001; vb[4] = 32'h3F800000; ey[4] = 32'h7FC00000; ef[4] = 4'b1000;
        va[5] = 32'h7F800000; vb[5] = 32'hC0000000; ey[5] = 32'hFF800000; ef[5] = 4'b0000;
        va[6] = 32'h80000000; vb[6] = 32'h40400000; ey[6] = 32'h80000000; ef[6] = 4'b0000;
        for (int i = 0; i < 7; i++) begin
            run_one(va[i], vb[i], ov, ty, tf);
            tests++; if (ty !== ey[i]) begin fails++; $display("FAIL special%0d_y: got %h expected %h", i, ty, ey[i]); end
            tests++; if (tf !== ef[i]) begin fails++; $display("FAIL special%0d_flags: got %b expected %b", i, tf, ef[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta [8];
        logic [31:0] ey [8];
        logic [31:0] held;
        int          in_idx;
        int          out_idx;
        logic        fire_in;
        logic        fire_out;
        ta[0] = 32'h3F800000; ta[1] = 32'h40000000; ta[2] = 32'h40400000; ta[3] = 32'h40800000;
        ta[4] = 32'h40A00000; ta[5] = 32'h40C00000; ta[6] = 32'h40E00000; ta[7] = 32'h41000000;
        ey[0] = 32'h40000000; ey[1] = 32'h40800000; ey[2] = 32'h40C00000; ey[3] = 32'h41000000;
        ey[4] = 32'h41200000; ey[5] = 32'h41400000; ey[6] = 32'h41600000; ey[7] = 32'h41800000;
        in_idx  = 0;
        out_idx = 0;
        held    = '0;
        for (int c = 0; c < 30; c++) begin
            bus.out_ready = !(c >= 4 && c <= 6);
            if (in_idx < 8) begin
                bus.in_valid = 1'b1;
                bus.a        = ta[in_idx];
                bus.b        = 32'h40000000;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (c >= 4 && c <= 6) begin
                tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready c%0d: got %b expected 0", c, bus.in_ready); end
            end
            if (c == 4) held = bus.y;
            if (c == 5 || c == 6) begin
                tests++; if (bus.y !== held) begin fails++; $display("FAIL stall_hold c%0d: got %h expected %h", c, bus.y, held); end
            end
            fire_in  = bus.in_valid && bus.in_ready;
            fire_out = bus.out_valid && bus.out_ready;
            if (fire_out) begin
                if (out_idx < 8) begin
                    tests++; if (bus.y !== ey[out_idx]) begin fails++; $display("FAIL stream_y%0d: got %h expected %h", out_idx, bus.y, ey[out_idx]); end
                end else begin
                    tests++; fails++; $display("FAIL stream_extra: got result %h expected none", bus.y);
                end
                out_idx++;
            end
            if (fire_in) in_idx++;
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tests++; if (out_idx != 8) begin fails++; $display("FAIL stream_count: got %0d expected 8", out_idx); end
        tests++; if (in_idx != 8) begin fails++; $display("FAIL stream_accepted: got %0d expected 8", in_idx); end
    endtask

`ifdef FMUL_STICKY_EN
    task automatic test_sticky();
        logic        ov;
        logic [31:0] ty;
        logic [3:0]  tf;
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        tests++; if (sticky !== 4'b0000) begin fails++; $display("FAIL sticky_preclear: got %b expected 0000", sticky); end
        run_one(32'h7F000000, 32'h7F000000, ov, ty, tf);
        run_one(32'h7F800000, 32'h00000000, ov, ty, tf);
        step();
        tests++; if (sticky !== 4'b1101) begin fails++; $display("FAIL sticky_accum: got %b expected 1101", sticky); end
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        tests++; if (sticky !== 4'b0000) begin fails++; $display("FAIL sticky_clear: got %b expected 0000", sticky); end
    endtask
`endif

    task automatic test_reset_inflight();
        logic        ov;
        logic [31:0] ty;
        logic [3:0]  tf;
        logic        seen;
        run_one(32'h3F800001, 32'h3F800001, ov, ty, tf);
        step();
        bus.in_valid = 1'b1;
        bus.a        = 32'h3FC00000;
        bus.b        = 32'h40000000;
        step();
        bus.a        = 32'h40400000;
        step();
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid: got %b expected 0", bus.out_valid); end
        tests++; if (bus.y !== 32'h0) begin fails++; $display("FAIL rst_mid_y: got %h expected 00000000", bus.y); end
        tests++; if (bus.flags !== 4'h0) begin fails++; $display("FAIL rst_mid_flags: got %b expected 0000", bus.flags); end
        step(); step();
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rst_mid_ghost: got out_valid after release, expected none"); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_latency();
        step();
        test_arith();
        step();
        test_specials();
        step();
        test_back_to_back();
`ifdef FMUL_STICKY_EN
        test_sticky();
`endif
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
